// File: rtl/uart_fifo_intf_if.sv
// Register-bus and engine-side signals of the UART FIFO front-end.
// slave = the front-end itself, master = CPU bus plus TX/RX engines.
interface uart_fifo_intf_if #(
  parameter int REG_AW = 16,
  parameter int REG_DW = 16,
  parameter int CHAR_W = 8,
  parameter int BAUD_W = 16
);
  logic [REG_AW-1:0] reg_addr;
  logic              reg_cs_n;
  logic              reg_wr_n;
  logic              reg_rd_n;
  logic [REG_DW-1:0] reg_wdata;
  logic [REG_DW-1:0] reg_rdata;
  logic              tx_valid;
  logic [CHAR_W-1:0] tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [CHAR_W-1:0] rx_data;
  logic              rx_err;
  logic [BAUD_W-1:0] baud_div;
  logic              uart_en;
  logic              irq_tx;
  logic              irq_rx;
  logic              irq_err;

  modport slave (
    input  reg_addr, reg_cs_n, reg_wr_n, reg_rd_n, reg_wdata,
    input  tx_ready, rx_valid, rx_data, rx_err,
    output reg_rdata, tx_valid, tx_data, baud_div, uart_en,
    output irq_tx, irq_rx, irq_err
  );

  modport master (
    output reg_addr, reg_cs_n, reg_wr_n, reg_rd_n, reg_wdata,
    output tx_ready, rx_valid, rx_data, rx_err,
    input  reg_rdata, tx_valid, tx_data, baud_div, uart_en,
    input  irq_tx, irq_rx, irq_err
  );
endinterface

// File: rtl/uart_fifo_intf.sv
// UART register front-end: CPU register bus, TX/RX FIFOs, baud divisor,
// sticky error status and registered level-threshold interrupts.
module uart_fifo_intf #(
  parameter int          REG_AW   = 16,
  parameter int          REG_DW   = 16,
  parameter int          CHAR_W   = 8,
  parameter int          TX_DEPTH = 16,
  parameter int          RX_DEPTH = 16,
  parameter int          BAUD_W   = 16,
  parameter logic [BAUD_W-1:0] BAUD_RST = 'h0341
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_fifo_intf_if.slave  bus
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);

  localparam logic [REG_AW-1:0] A_CTRL  = REG_AW'('h00);
  localparam logic [REG_AW-1:0] A_STAT  = REG_AW'('h04);
  localparam logic [REG_AW-1:0] A_TXD   = REG_AW'('h08);
  localparam logic [REG_AW-1:0] A_RXD   = REG_AW'('h0C);
  localparam logic [REG_AW-1:0] A_IEN   = REG_AW'('h10);
  localparam logic [REG_AW-1:0] A_TXTHR = REG_AW'('h14);
  localparam logic [REG_AW-1:0] A_RXTHR = REG_AW'('h18);
  localparam logic [REG_AW-1:0] A_BAUD  = REG_AW'('h1C);
  localparam logic [REG_AW-1:0] A_TXCNT = REG_AW'('h20);
  localparam logic [REG_AW-1:0] A_RXCNT = REG_AW'('h24);

  logic              w_wr_cs, w_rd_cs, r_wr_cs_d, r_rd_cs_d, w_wr_p, w_rd_p;
  logic              w_wr_ctrl, w_wr_stat;
  logic              r_tx_en, r_rx_en, r_uart_en;
  logic [2:0]        r_ien;
  logic [TXA:0]      r_txthr;
  logic [RXA:0]      r_rxthr;
  logic [BAUD_W-1:0] r_baud;
  logic              r_rx_ovr, r_rx_perr, r_tx_ovr;
  logic              r_irq_tx, r_irq_rx, r_irq_err;
  logic [REG_DW-1:0] r_rdata, w_rdata;

  logic [CHAR_W-1:0] r_tx_mem [TX_DEPTH];
  logic [TXA:0]      r_tx_wp, r_tx_rp, w_tx_cnt;
  logic              w_tx_empty, w_tx_full, w_tx_valid, w_tx_clr;
  logic              w_tx_pop, w_tx_req, w_tx_push, w_tx_ovr_set;

  logic [CHAR_W-1:0] r_rx_mem [RX_DEPTH];
  logic [RXA:0]      r_rx_wp, r_rx_rp, w_rx_cnt;
  logic              w_rx_empty, w_rx_full, w_rx_clr;
  logic              w_rx_pop, w_rx_req, w_rx_push, w_rx_ovr_set, w_rx_perr_set;

  assign w_wr_cs   = ~(bus.reg_wr_n | bus.reg_cs_n);
  assign w_rd_cs   = ~(bus.reg_rd_n | bus.reg_cs_n);
  assign w_wr_p    = w_wr_cs & ~r_wr_cs_d;
  assign w_rd_p    = w_rd_cs & ~r_rd_cs_d;
  assign w_wr_ctrl = w_wr_p & (bus.reg_addr == A_CTRL);
  assign w_wr_stat = w_wr_p & (bus.reg_addr == A_STAT);

  // TX FIFO: a disabled or cleared FIFO is emptied and ignores pushes.
  assign w_tx_cnt     = r_tx_wp - r_tx_rp;
  assign w_tx_empty   = (r_tx_wp == r_tx_rp);
  assign w_tx_full    = (r_tx_wp[TXA] != r_tx_rp[TXA]) &&
                        (r_tx_wp[TXA-1:0] == r_tx_rp[TXA-1:0]);
  assign w_tx_clr     = ~r_tx_en | (w_wr_ctrl & bus.reg_wdata[2]);
  assign w_tx_valid   = r_tx_en & ~w_tx_empty;
  assign w_tx_pop     = w_tx_valid & bus.tx_ready;
  assign w_tx_req     = w_wr_p & (bus.reg_addr == A_TXD);
  assign w_tx_push    = w_tx_req & (~w_tx_full | w_tx_pop) & ~w_tx_clr;
  assign w_tx_ovr_set = w_tx_req & w_tx_full & ~w_tx_pop & ~w_tx_clr;

  assign w_rx_cnt      = r_rx_wp - r_rx_rp;
  assign w_rx_empty    = (r_rx_wp == r_rx_rp);
  assign w_rx_full     = (r_rx_wp[RXA] != r_rx_rp[RXA]) &&
                         (r_rx_wp[RXA-1:0] == r_rx_rp[RXA-1:0]);
  assign w_rx_clr      = ~r_rx_en | (w_wr_ctrl & bus.reg_wdata[3]);
  assign w_rx_pop      = w_rd_p & (bus.reg_addr == A_RXD) & ~w_rx_empty;
  assign w_rx_req      = bus.rx_valid & r_rx_en;
  assign w_rx_push     = w_rx_req & (~w_rx_full | w_rx_pop) & ~w_rx_clr;
  assign w_rx_ovr_set  = w_rx_req & w_rx_full & ~w_rx_pop & ~w_rx_clr;
  assign w_rx_perr_set = w_rx_req & bus.rx_err & ~w_rx_clr;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TXA-1:0]] <= bus.reg_wdata[CHAR_W-1:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[RXA-1:0]] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_tx_clr) begin
        r_tx_wp <= '0;
        r_tx_rp <= '0;
      end else begin
        if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
        if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      end
      if (w_rx_clr) begin
        r_rx_wp <= '0;
        r_rx_rp <= '0;
      end else begin
        if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
        if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_cs_d <= 1'b0;
      r_rd_cs_d <= 1'b0;
      r_tx_en   <= 1'b1;
      r_rx_en   <= 1'b1;
      r_uart_en <= 1'b1;
      r_ien     <= '0;
      r_txthr   <= '0;
      r_rxthr   <= '0;
      r_baud    <= BAUD_RST;
      r_rx_ovr  <= 1'b0;
      r_rx_perr <= 1'b0;
      r_tx_ovr  <= 1'b0;
      r_irq_tx  <= 1'b0;
      r_irq_rx  <= 1'b0;
      r_irq_err <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_wr_cs_d <= w_wr_cs;
      r_rd_cs_d <= w_rd_cs;
      if (w_wr_ctrl) begin
        r_tx_en <= bus.reg_wdata[0];
        r_rx_en <= bus.reg_wdata[1];
      end
      if (w_wr_p && bus.reg_addr == A_IEN)   r_ien   <= bus.reg_wdata[2:0];
      if (w_wr_p && bus.reg_addr == A_TXTHR) r_txthr <= bus.reg_wdata[TXA:0];
      if (w_wr_p && bus.reg_addr == A_RXTHR) r_rxthr <= bus.reg_wdata[RXA:0];
      if (w_wr_p && bus.reg_addr == A_BAUD)  r_baud  <= bus.reg_wdata[BAUD_W-1:0];
      r_uart_en <= r_tx_en | r_rx_en;
      // Set beats a same-cycle W1C.
      r_rx_ovr  <= w_rx_ovr_set  | (r_rx_ovr  & ~(w_wr_stat & bus.reg_wdata[4]));
      r_rx_perr <= w_rx_perr_set | (r_rx_perr & ~(w_wr_stat & bus.reg_wdata[5]));
      r_tx_ovr  <= w_tx_ovr_set  | (r_tx_ovr  & ~(w_wr_stat & bus.reg_wdata[6]));
      r_irq_tx  <= r_ien[0] & r_tx_en & (w_tx_cnt <= r_txthr);
      r_irq_rx  <= r_ien[1] & r_rx_en & (w_rx_cnt != '0) & (w_rx_cnt >= r_rxthr);
      r_irq_err <= r_ien[2] & (r_rx_ovr | r_rx_perr | r_tx_ovr);
      if (w_rd_cs) r_rdata <= w_rdata;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.reg_addr)
      A_CTRL:  w_rdata[1:0] = {r_rx_en, r_tx_en};
      A_STAT:  w_rdata[6:0] = {r_tx_ovr, r_rx_perr, r_rx_ovr,
                               w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
      A_RXD:   if (!w_rx_empty) w_rdata[CHAR_W-1:0] = r_rx_mem[r_rx_rp[RXA-1:0]];
      A_IEN:   w_rdata[2:0] = r_ien;
      A_TXTHR: w_rdata[TXA:0] = r_txthr;
      A_RXTHR: w_rdata[RXA:0] = r_rxthr;
      A_BAUD:  w_rdata[BAUD_W-1:0] = r_baud;
      A_TXCNT: w_rdata[TXA:0] = w_tx_cnt;
      A_RXCNT: w_rdata[RXA:0] = w_rx_cnt;
      default: w_rdata = '0;
    endcase
  end

  assign bus.reg_rdata = r_rdata;
  assign bus.tx_valid  = w_tx_valid;
  assign bus.tx_data   = r_tx_mem[r_tx_rp[TXA-1:0]];
  assign bus.baud_div  = r_baud;
  assign bus.uart_en   = r_uart_en;
  assign bus.irq_tx    = r_irq_tx;
  assign bus.irq_rx    = r_irq_rx;
  assign bus.irq_err   = r_irq_err;
endmodule
